// File: rtl/player_state_controller_pkg.sv
// Shared definitions for the per-player sequencer: state encodings, default
// frame counts and blast-zone bounds (also used by the HUD and the game top).
package player_state_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_ACTIVE    = 3'd2,
        ST_HITSTUN   = 3'd3,
        ST_RESPAWN   = 3'd4,
        ST_OVER      = 3'd5
    } player_state_t;

    localparam int unsigned DEF_STOCKS           = 3;
    localparam int unsigned DEF_COUNTDOWN_FRAMES = 180;
    localparam int unsigned DEF_RESPAWN_FRAMES   = 120;
    localparam int unsigned DEF_INVULN_FRAMES    = 90;

    localparam logic signed [15:0] DEF_X_MIN = -16'sd64;
    localparam logic signed [15:0] DEF_X_MAX = 16'sd704;
    localparam logic signed [15:0] DEF_Y_MIN = -16'sd64;
    localparam logic signed [15:0] DEF_Y_MAX = 16'sd544;

    function automatic logic outside_range(
        input logic signed [15:0] v,
        input logic signed [15:0] lo,
        input logic signed [15:0] hi
    );
        return (v < lo) || (v > hi);
    endfunction

endpackage

// File: rtl/player_state_controller_frame_timer.sv
// 8-bit frame down-counter; a load of 0 becomes 1 and done marks the
// decrement that reaches 0 (combinational, same cycle as the causing tick).
module frame_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    input  logic       hold,
    output logic [7:0] count,
    output logic       done
);

    assign done = tick && !hold && !load && (count == 8'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= (load_val == '0) ? 8'd1 : load_val;
        end else if (tick && !hold && (count != '0)) begin
            count <= count - 8'd1;
        end
    end

endmodule

// File: rtl/player_state_controller.sv
// Per-player phase sequencer driving one physics_coprocessor's reset, freeze
// and attack inputs; tracks stocks, blast-zone KOs and respawn invincibility.
module player_state_controller
    import player_state_controller_pkg::*;
#(
    parameter int unsigned        STOCKS           = DEF_STOCKS,
    parameter int unsigned        COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
    parameter int unsigned        RESPAWN_FRAMES   = DEF_RESPAWN_FRAMES,
    parameter int unsigned        INVULN_FRAMES    = DEF_INVULN_FRAMES,
    parameter logic signed [15:0] X_MIN            = DEF_X_MIN,
    parameter logic signed [15:0] X_MAX            = DEF_X_MAX,
    parameter logic signed [15:0] Y_MIN            = DEF_Y_MIN,
    parameter logic signed [15:0] Y_MAX            = DEF_Y_MAX
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        game_start,
    input  logic        pause,
    input  logic [31:0] position,
    input  logic        hit_valid,
    input  logic [7:0]  hitstun_frames,
    output logic        phys_reset,
    output logic        freeze,
    output logic        attack,
    output logic        invincible,
    output logic [3:0]  stocks,
    output logic        ko_pulse,
    output logic        game_over,
    output logic [2:0]  state
);

    player_state_t cur_state, state_n;
    logic [3:0]    stocks_n;
    logic          inv_n;
    logic          in_play, timed_phase, ko, hit;
    logic          phase_load, phase_tick, phase_done;
    logic [7:0]    phase_val, phase_count;
    logic          inv_load, inv_tick, inv_done;
    logic [7:0]    inv_count;

    assign state = cur_state;

    assign in_play     = (cur_state == ST_ACTIVE) || (cur_state == ST_HITSTUN);
    assign timed_phase = (cur_state == ST_COUNTDOWN) || (cur_state == ST_HITSTUN) ||
                         (cur_state == ST_RESPAWN);

    // KO is checked every clock while in play, regardless of pause or invincibility.
    assign ko  = in_play && (outside_range($signed(position[31:16]), X_MIN, X_MAX) ||
                             outside_range($signed(position[15:0]),  Y_MIN, Y_MAX));
    assign hit = in_play && hit_valid && !pause && !invincible;

    assign phase_tick = frame_tick && timed_phase && (phase_count != '0);
    assign inv_tick   = frame_tick && in_play && invincible && (inv_count != '0);

    frame_timer u_phase_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (phase_load),
        .load_val (phase_val),
        .tick     (phase_tick),
        .hold     (pause),
        .count    (phase_count),
        .done     (phase_done)
    );

    frame_timer u_invuln_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (inv_load),
        .load_val (8'(INVULN_FRAMES)),
        .tick     (inv_tick),
        .hold     (pause),
        .count    (inv_count),
        .done     (inv_done)
    );

    always_comb begin
        state_n    = cur_state;
        stocks_n   = stocks;
        inv_n      = invincible;
        phase_load = 1'b0;
        phase_val  = '0;
        inv_load   = 1'b0;

        if (inv_done) begin
            inv_n = 1'b0;
        end

        case (cur_state)
            ST_IDLE: begin
                if (game_start) begin
                    state_n    = ST_COUNTDOWN;
                    phase_load = 1'b1;
                    phase_val  = 8'(COUNTDOWN_FRAMES);
                end
            end
            ST_COUNTDOWN: begin
                if (phase_done) begin
                    state_n = ST_ACTIVE;
                end
            end
            ST_ACTIVE, ST_HITSTUN: begin
                // KO outranks a same-cycle hit; a re-hit outranks the expiring tick.
                if (ko) begin
                    stocks_n = (stocks == '0) ? '0 : stocks - 4'd1;
                    inv_n    = 1'b0;
                    if (stocks <= 4'd1) begin
                        state_n = ST_OVER;
                    end else begin
                        state_n    = ST_RESPAWN;
                        phase_load = 1'b1;
                        phase_val  = 8'(RESPAWN_FRAMES);
                    end
                end else if (hit) begin
                    state_n    = ST_HITSTUN;
                    phase_load = 1'b1;
                    phase_val  = hitstun_frames;
                end else if ((cur_state == ST_HITSTUN) && phase_done) begin
                    state_n = ST_ACTIVE;
                end
            end
            ST_RESPAWN: begin
                if (phase_done) begin
                    state_n  = ST_ACTIVE;
                    inv_n    = 1'b1;
                    inv_load = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_state  <= ST_IDLE;
            phys_reset <= 1'b1;
            freeze     <= 1'b1;
            attack     <= 1'b0;
            invincible <= 1'b0;
            stocks     <= 4'(STOCKS);
            ko_pulse   <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            cur_state  <= state_n;
            stocks     <= stocks_n;
            invincible <= inv_n;
            ko_pulse   <= ko;
            phys_reset <= (state_n == ST_IDLE) || (state_n == ST_RESPAWN) ||
                          (state_n == ST_OVER);
            freeze     <= pause || !((state_n == ST_ACTIVE) || (state_n == ST_HITSTUN));
            attack     <= (state_n == ST_HITSTUN);
            game_over  <= (state_n == ST_OVER);
        end
    end

endmodule
